// File: rtl/hssl_link_ctrl_pkg.sv
// Shared definitions for the HSSL link bring-up sequencer: state encodings and
// default timing constants, so status decode elsewhere uses the same values.
package hssl_link_ctrl_pkg;

    typedef enum logic [2:0] {
        STATE_WAIT_CLK  = 3'd0,
        STATE_RST_DP    = 3'd1,
        STATE_WAIT_DONE = 3'd2,
        STATE_WAIT_HS   = 3'd3,
        STATE_UP        = 3'd4
    } link_state_t;

    localparam int LEN_RST_DEF    = 128;
    localparam int DONE_TO_DEF    = 1000000;
    localparam int HS_TO_DEF      = 75000000;
    localparam int ERR_THRESH_DEF = 16;
    localparam int ERR_WIN_DEF    = 65536;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hssl_err_window.sv
// Rx error-rate monitor: fixed-length window timer plus a saturating error
// counter; trip_out asserts once ERR_THRESH errors land in one window.
module hssl_err_window
    import hssl_link_ctrl_pkg::*;
#(
    parameter int ERR_THRESH = ERR_THRESH_DEF,
    parameter int ERR_WIN    = ERR_WIN_DEF
) (
    input  logic freerun_clk_in,
    input  logic reset_n_in,
    input  logic enable_in,
    input  logic rx_err_in,
    output logic trip_out
);

    localparam int WIN_W = $clog2(ERR_WIN + 1);
    localparam int CNT_W = $clog2(ERR_THRESH + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ERR_WIN - 1);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(ERR_THRESH);

    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q;

    // Held clear while disabled, so every enable restarts a fresh window.
    always_ff @(posedge freerun_clk_in) begin
        if (!reset_n_in || !enable_in) begin
            win_q <= '0;
            cnt_q <= '0;
        end else if (win_q == WIN_LAST) begin
            win_q <= '0;
            cnt_q <= rx_err_in ? CNT_W'(1) : '0;
        end else begin
            win_q <= win_q + 1'b1;
            if (rx_err_in && (cnt_q != CNT_TRIP))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign trip_out = enable_in && (cnt_q == CNT_TRIP);

endmodule

// File: rtl/hssl_link_ctrl.sv
// HSSL link bring-up/recovery sequencer. Optional rx error monitor is built
// when HSSL_LINK_CTRL_ERR_MON_EN is defined.
module hssl_link_ctrl
    import hssl_link_ctrl_pkg::*;
#(
    parameter int LEN_RST    = LEN_RST_DEF,
    parameter int DONE_TO    = DONE_TO_DEF,
    parameter int HS_TO      = HS_TO_DEF,
    parameter int ERR_THRESH = ERR_THRESH_DEF,
    parameter int ERR_WIN    = ERR_WIN_DEF
) (
    input  logic       freerun_clk_in,
    input  logic       reset_n_in,
    input  logic       tx_usrclk_active_in,
    input  logic       tx_reset_done_in,
    input  logic       rx_reset_done_in,
    input  logic       handshake_complete_in,
    input  logic       rx_err_in,
    input  logic       sw_reset_req_in,
    output logic       tx_reset_datapath_out,
    output logic       rx_reset_datapath_out,
    output logic       tx_elec_idle_out,
    output logic       link_up_out,
    output logic [2:0] state_out,
    output logic [7:0] retry_cnt_out
);

    localparam int TMR_W = $clog2(max3(LEN_RST, DONE_TO, HS_TO) + 1);
    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(LEN_RST - 1);
    localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(DONE_TO - 1);
    localparam logic [TMR_W-1:0] HS_LAST   = TMR_W'(HS_TO - 1);

    logic [3:0]       sync_q1, sync_q2;
    logic             clk_ok, tx_done, rx_done, hs_ok;
    link_state_t      state_q, state_nxt;
    logic [TMR_W-1:0] tmr_q;
    logic             tmr_clr, retry_inc, err_trip, dp_rst_nxt;
    logic [7:0]       retry_q;

    always_ff @(posedge freerun_clk_in) begin
        if (!reset_n_in) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {tx_usrclk_active_in, tx_reset_done_in, rx_reset_done_in, handshake_complete_in};
            sync_q2 <= sync_q1;
        end
    end

    assign {clk_ok, tx_done, rx_done, hs_ok} = sync_q2;

`ifdef HSSL_LINK_CTRL_ERR_MON_EN
    hssl_err_window #(
        .ERR_THRESH (ERR_THRESH),
        .ERR_WIN    (ERR_WIN)
    ) u_err_window (
        .freerun_clk_in (freerun_clk_in),
        .reset_n_in     (reset_n_in),
        .enable_in      (state_q == STATE_UP),
        .rx_err_in      (rx_err_in),
        .trip_out       (err_trip)
    );
`else
    logic unused_err_mon;
    assign unused_err_mon = rx_err_in ^ (ERR_THRESH > 0) ^ (ERR_WIN > 0);
    assign err_trip       = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        tmr_clr   = 1'b0;
        retry_inc = 1'b0;
        if (!clk_ok) begin
            state_nxt = STATE_WAIT_CLK;
        end else if (sw_reset_req_in && (state_q != STATE_WAIT_CLK)) begin
            // Also restarts the reset pulse when already in RST_DP.
            state_nxt = STATE_RST_DP;
            tmr_clr   = 1'b1;
            retry_inc = 1'b1;
        end else begin
            case (state_q)
                STATE_WAIT_CLK: state_nxt = STATE_RST_DP;
                STATE_RST_DP: begin
                    if (tmr_q == RST_LAST)
                        state_nxt = STATE_WAIT_DONE;
                end
                STATE_WAIT_DONE: begin
                    if (tx_done && rx_done) begin
                        state_nxt = STATE_WAIT_HS;
                    end else if (tmr_q == DONE_LAST) begin
                        state_nxt = STATE_RST_DP;
                        retry_inc = 1'b1;
                    end
                end
                STATE_WAIT_HS: begin
                    if (hs_ok) begin
                        state_nxt = STATE_UP;
                    end else if (tmr_q == HS_LAST) begin
                        state_nxt = STATE_RST_DP;
                        retry_inc = 1'b1;
                    end
                end
                STATE_UP: begin
                    if (!hs_ok || err_trip) begin
                        state_nxt = STATE_RST_DP;
                        retry_inc = 1'b1;
                    end
                end
                default: state_nxt = STATE_WAIT_CLK;
            endcase
        end
        if (state_nxt != state_q)
            tmr_clr = 1'b1;
    end

    assign dp_rst_nxt = (state_nxt == STATE_WAIT_CLK) || (state_nxt == STATE_RST_DP);

    // Outputs decode the next state so they change on the same edge as state.
    always_ff @(posedge freerun_clk_in) begin
        if (!reset_n_in) begin
            state_q               <= STATE_WAIT_CLK;
            tmr_q                 <= '0;
            retry_q               <= '0;
            tx_reset_datapath_out <= 1'b1;
            rx_reset_datapath_out <= 1'b1;
            tx_elec_idle_out      <= 1'b1;
            link_up_out           <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (tmr_clr)
                tmr_q <= '0;
            else if ((state_q == STATE_RST_DP) || (state_q == STATE_WAIT_DONE) ||
                     (state_q == STATE_WAIT_HS))
                tmr_q <= tmr_q + 1'b1;
            if (retry_inc && (retry_q != 8'hFF))
                retry_q <= retry_q + 8'd1;
            tx_reset_datapath_out <= dp_rst_nxt;
            rx_reset_datapath_out <= dp_rst_nxt;
            tx_elec_idle_out      <= dp_rst_nxt;
            link_up_out           <= (state_nxt == STATE_UP);
        end
    end

    assign state_out     = state_q;
    assign retry_cnt_out = retry_q;

endmodule
